// File: rtl/sincos_arbiter.sv
// sincos_arbiter: round-robin sharing of one quarter-wave sin/cos ROM.
// A winner's angle (0..47, 7.5 degree steps; 48..63 wrap by subtracting 48)
// is split into quadrant and quarter-wave index. The index drives the ROM.
// After ROM_LAT clocks the magnitudes are folded into signed Q1.7 sin/cos,
// and a one-cycle done strobe goes back to the requester that was served.
module sincos_arbiter #(
  parameter int N_REQ   = 4,
  parameter int ROM_LAT = 1
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic [N_REQ-1:0]     req,
  input  logic [6*N_REQ-1:0]   angle,
  output logic [3:0]           rom_addr,
  input  logic [7:0]           rom_sin,
  input  logic [7:0]           rom_cos,
  output logic                 busy,
  output logic [2:0]           grant_id,
  output logic [N_REQ-1:0]     done,
  output logic [8:0]           sin_out,
  output logic [8:0]           cos_out
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_r;
  logic [2:0]       ptr_r;
  logic [1:0]       cnt_r;
  logic [1:0]       quad_r;

  logic [7:0]       req_pad_s;
  logic [47:0]      angle_pad_s;
  logic [3:0]       cand_s;
  logic             win_found_s;
  logic [2:0]       win_idx_s;
  logic [5:0]       win_angle_s;
  logic [5:0]       red_angle_s;
  logic [1:0]       win_quad_s;
  logic [3:0]       win_rem_s;
  logic [17:0]      fold_s;
  logic [N_REQ-1:0] done_next_s;
  logic [2:0]       ptr_next_s;

  // Map a quarter-wave magnitude pair onto the full circle: {sin, cos}.
  // Zero-extended to 9 bits, so negating 0 gives 0 and -128 fits.
  function automatic logic [17:0] fold(input logic [1:0] quad,
                                       input logic [7:0] s,
                                       input logic [7:0] c);
    logic [8:0] sp;
    logic [8:0] cp;
    logic [8:0] sn;
    logic [8:0] cn;
    sp = {1'b0, s};
    cp = {1'b0, c};
    sn = 9'd0 - sp;
    cn = 9'd0 - cp;
    case (quad)
      2'd0:    fold = {sp, cp};
      2'd1:    fold = {cp, sn};
      2'd2:    fold = {sn, cn};
      2'd3:    fold = {cn, sp};
      default: fold = {sp, cp};
    endcase
  endfunction

  // Pad request/angle buses to the 8-requester maximum so indexing is uniform.
  assign req_pad_s   = 8'(req);
  assign angle_pad_s = 48'(angle);
  assign fold_s      = fold(quad_r, rom_sin, rom_cos);

  // Round-robin search: first asserted request at or after the pointer, wrapping.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = 3'd0;
    cand_s      = 4'd0;
    for (int i = 0; i < N_REQ; i++) begin
      cand_s = {1'b0, ptr_r} + 4'(i);
      if (cand_s >= 4'(N_REQ)) begin
        cand_s = cand_s - 4'(N_REQ);
      end else begin
        cand_s = cand_s;
      end
      if (!win_found_s && req_pad_s[cand_s[2:0]]) begin
        win_found_s = 1'b1;
        win_idx_s   = cand_s[2:0];
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Select the winning requester's angle field.
  always_comb begin
    win_angle_s = 6'd0;
    for (int i = 0; i < 8; i++) begin
      if (win_idx_s == 3'(i)) begin
        win_angle_s = angle_pad_s[6*i +: 6];
      end else begin
        win_angle_s = win_angle_s;
      end
    end
  end

  // Wrap out-of-range angles, then split into quadrant and index 0..11.
  always_comb begin
    if (win_angle_s >= 6'd48) begin
      red_angle_s = win_angle_s - 6'd48;
    end else begin
      red_angle_s = win_angle_s;
    end
    if (red_angle_s >= 6'd36) begin
      win_quad_s = 2'd3;
      win_rem_s  = 4'(red_angle_s - 6'd36);
    end else if (red_angle_s >= 6'd24) begin
      win_quad_s = 2'd2;
      win_rem_s  = 4'(red_angle_s - 6'd24);
    end else if (red_angle_s >= 6'd12) begin
      win_quad_s = 2'd1;
      win_rem_s  = 4'(red_angle_s - 6'd12);
    end else begin
      win_quad_s = 2'd0;
      win_rem_s  = 4'(red_angle_s);
    end
  end

  // One-hot done vector and next round-robin pointer for the served requester.
  always_comb begin
    done_next_s = {N_REQ{1'b0}};
    for (int i = 0; i < N_REQ; i++) begin
      done_next_s[i] = (grant_id == 3'(i));
    end
    if (grant_id == 3'(N_REQ - 1)) begin
      ptr_next_s = 3'd0;
    end else begin
      ptr_next_s = grant_id + 3'd1;
    end
  end

  // Control FSM: capture a winner, wait out ROM latency, publish folded result.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r  <= ST_IDLE;
      ptr_r    <= 3'd0;
      cnt_r    <= 2'd0;
      quad_r   <= 2'd0;
      rom_addr <= 4'd0;
      busy     <= 1'b0;
      grant_id <= 3'd0;
      done     <= {N_REQ{1'b0}};
      sin_out  <= 9'd0;
      cos_out  <= 9'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (win_found_s) begin
            grant_id <= win_idx_s;
            rom_addr <= win_rem_s;
            quad_r   <= win_quad_s;
            busy     <= 1'b1;
            cnt_r    <= 2'(ROM_LAT - 1);
            state_r  <= ST_WAIT;
          end else begin
            state_r  <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (cnt_r == 2'd0) begin
            sin_out <= fold_s[17:9];
            cos_out <= fold_s[8:0];
            done    <= done_next_s;
            state_r <= ST_DONE;
          end else begin
            cnt_r   <= cnt_r - 2'd1;
          end
        end
        ST_DONE: begin
          done    <= {N_REQ{1'b0}};
          busy    <= 1'b0;
          ptr_r   <= ptr_next_s;
          state_r <= ST_IDLE;
        end
        default: begin
          done    <= {N_REQ{1'b0}};
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
